fp_unpack: RTL and testbench
============================

# fp_unpack

Parametrised, pipelined floating-point unpacker for the FPU front end. Splits an IEEE-754-style operand of configurable format into sign, exponent and mantissa, classifies it, and pre-normalises denormals so downstream datapaths only ever see a leading-one mantissa. It sits between the operand register read and the FPU arithmetic units, with valid/ready handshakes on both sides.

## Interface
- EXP_W, 8: stored exponent width (binary32 default).
- MAN_W, 23: stored fraction width; requires MAN_W < 2^(EXP_W+1).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  unpacker accepts operand this cycle.
- float_in  in  1+EXP_W+MAN_W  packed operand {sgn, exp, frac}.
- daz  in  1  denormals-are-zero mode, sampled with the operand.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sgn  out  1  sign.
- Exp  out  EXP_W+2  signed biased exponent, denormals extended below 1.
- man  out  MAN_W+1  mantissa incl. hidden bit, normalised for finite nonzero.
- zero, inf, sNaN, qNaN, denormal  out  1 each  class flags (denormal = input was subnormal, even if flushed by daz).
- fclass  out  10  one-hot class mask: bit0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.

## Operation
- Fields: e = float_in[MAN_W+EXP_W-1:MAN_W], f = float_in[MAN_W-1:0].
- Normal (0 < e < all-ones): man = {1, f}, Exp = e zero-extended.
- Zero (e = 0, f = 0): man = 0, Exp = 0, zero = 1.
- Denormal (e = 0, f != 0), daz = 0: m = {0, f}; s = leading-zero count of m (1..MAN_W); man = m << s; Exp = 1 - s (two's complement, EXP_W+2 bits); denormal = 1.
- Denormal with daz = 1: treated as zero of same sign (man = 0, Exp = 0, zero = 1, fclass zero bit), denormal = 1 still reported.
- Inf (e all-ones, f = 0): man = {1, 0}, Exp = e, inf = 1.
- NaN (e all-ones, f != 0): man = {1, f}, Exp = e; f[MAN_W-1] = 1 -> qNaN, else sNaN.
- Exactly one fclass bit set for every valid result; flags consistent with fclass.
- Stage 1: register operand fields, daz, class decode and leading-zero count. Stage 2: barrel shift, exponent computation, register all outputs.

## Timing
- Reset: out_valid = 0, internal stage valids = 0, all data outputs and flags = 0; in_ready = 1 after reset deasserts.
- Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
- Latency: 2 cycles from accepted input to out_valid with no stall; throughput 1 operand/cycle.
- Stage advance: s2_ready = !s2_valid || out_ready; in_ready = !s1_valid || s2_ready. out_ready may combinationally reach in_ready; no combinational path from float_in to any output.
- Stall: while out_valid && !out_ready, all outputs hold stable; stage 1 holds once full; no operand dropped or duplicated.
- Bubbles: stage valids clear when a stage empties; data registers need not clear, but outputs are only meaningful with out_valid.
- Simultaneous accept and emit in one cycle permitted in every stage.
- Reset mid-operation: all in-flight operands discarded, outputs return to reset values immediately.

## Test plan
- Normal: 0x3F800000, daz=0 -> 2 cycles later out_valid, sgn=0, Exp=0x07F, man=0x800000, fclass=0x040.
- Smallest denormal: 0x00000001, daz=0 -> man=0x800000, Exp=0x3EA (-22), denormal=1, fclass=0x020; same with daz=1 -> man=0, Exp=0, zero=1, denormal=1, fclass=0x010.
- Specials: 0xFF800000 -> inf=1, fclass=0x001; 0x7FC00000 -> qNaN=1, fclass=0x200; 0x7F800001 -> sNaN=1, fclass=0x100; 0x80000000 -> zero=1, fclass=0x008.
- Backpressure: stream 8 random operands with out_ready low for 5 cycles mid-burst -> outputs stable while stalled, in_ready drops after 2 held operands, all 8 results delivered in order matching model.
- Full throughput: out_ready=1, in_valid=1 for 100 cycles -> 100 results on consecutive cycles.
- Reset mid-stream: assert reset with both stages full -> out_valid=0 and outputs 0 asynchronously; first operand after release emerges exactly 2 cycles after acceptance. Repeat a subset with EXP_W=11, MAN_W=52 (0x0000000000000001 -> Exp=-51).

Source files
------------

// File: rtl/fp_unpack.sv
// fp_unpack: two-stage pipelined floating-point operand unpacker.
//
// Splits a packed {sgn, exp, frac} operand into sign, signed biased exponent
// and hidden-bit mantissa, classifies it, and pre-normalises subnormals so
// every finite nonzero result carries a leading one in man[MAN_W].
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake for float_in and daz
//   float_in            packed operand, width 1+EXP_W+MAN_W
//   daz                 denormals-are-zero, captured with the operand
//   out_valid/out_ready output handshake
//   sgn, Exp, man       unpacked fields (Exp is signed, EXP_W+2 bits)
//   zero, inf, sNaN, qNaN, denormal   class flags
//   fclass              one-hot class mask
//
// Stage 1 registers fields, daz, class decode and leading-zero count.
// Stage 2 performs the normalising shift and exponent adjust and registers
// every output, so no combinational path exists from float_in to outputs.
module fp_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   float_in,
    input  logic                   daz,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sgn,
    output logic [EXP_W+1:0]       Exp,
    output logic [MAN_W:0]         man,
    output logic                   zero,
    output logic                   inf,
    output logic                   sNaN,
    output logic                   qNaN,
    output logic                   denormal,
    output logic [9:0]             fclass
);
    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam int XW   = EXP_W + 2;

    // ---------------- stage 1: field split and classify ----------------
    logic [EXP_W-1:0] e_in;
    logic [MAN_W-1:0] f_in;
    logic             e_zero, e_ones, f_zero;
    logic [LZ_W-1:0]  lz_d;

    assign e_in   = float_in[MAN_W+EXP_W-1:MAN_W];
    assign f_in   = float_in[MAN_W-1:0];
    assign e_zero = (e_in == '0);
    assign e_ones = &e_in;
    assign f_zero = (f_in == '0);

    // Leading zeros of {1'b0, f}: the highest set fraction bit wins because
    // later loop iterations override earlier ones. Only used for subnormals,
    // so the all-zero fraction value is irrelevant.
    always_comb begin
        lz_d = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (f_in[i]) lz_d = LZ_W'(MAN_W - i);
        end
    end

    logic             s1_valid_q;
    logic             s1_sgn_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MAN_W-1:0] s1_frac_q;
    logic             s1_daz_q;
    logic             s1_zero_q, s1_sub_q, s1_norm_q, s1_inf_q, s1_nan_q;
    logic [LZ_W-1:0]  s1_lz_q;
    logic             s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_daz_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_norm_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_lz_q    <= '0;
        end else if (in_ready) begin
            // Stage 1 is empty or draining into stage 2 this cycle.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sgn_q  <= float_in[MAN_W+EXP_W];
                s1_exp_q  <= e_in;
                s1_frac_q <= f_in;
                s1_daz_q  <= daz;
                s1_zero_q <= e_zero && f_zero;
                s1_sub_q  <= e_zero && !f_zero;
                s1_norm_q <= !e_zero && !e_ones;
                s1_inf_q  <= e_ones && f_zero;
                s1_nan_q  <= e_ones && !f_zero;
                s1_lz_q   <= lz_d;
            end
        end
    end

    // ---------------- stage 2: normalise and build outputs ----------------
    logic [XW-1:0]    exp_d;
    logic [MAN_W:0]   man_d;
    logic             zero_d, sub_keep, snan_d, qnan_d;
    logic [9:0]       fclass_d;

    always_comb begin
        exp_d = '0;
        man_d = '0;
        // A subnormal survives as a subnormal only when not flushed.
        sub_keep = s1_sub_q && !s1_daz_q;
        zero_d   = s1_zero_q || (s1_sub_q && s1_daz_q);
        qnan_d   = s1_nan_q && s1_frac_q[MAN_W-1];
        snan_d   = s1_nan_q && !s1_frac_q[MAN_W-1];
        if (s1_norm_q || s1_inf_q || s1_nan_q) begin
            // Inf has a zero fraction, so {1, f} gives {1, 0} for it.
            man_d = {1'b1, s1_frac_q};
            exp_d = XW'(s1_exp_q);
        end else if (sub_keep) begin
            man_d = {1'b0, s1_frac_q} << s1_lz_q;
            exp_d = XW'(1) - XW'(s1_lz_q);
        end
        fclass_d = {qnan_d,
                    snan_d,
                    s1_inf_q  && !s1_sgn_q,
                    s1_norm_q && !s1_sgn_q,
                    sub_keep  && !s1_sgn_q,
                    zero_d    && !s1_sgn_q,
                    zero_d    &&  s1_sgn_q,
                    sub_keep  &&  s1_sgn_q,
                    s1_norm_q &&  s1_sgn_q,
                    s1_inf_q  &&  s1_sgn_q};
    end

    logic             out_valid_q, sgn_q, zero_q, inf_q, snan_q, qnan_q, den_q;
    logic [XW-1:0]    exp_q;
    logic [MAN_W:0]   man_q;
    logic [9:0]       fclass_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sgn_q       <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            snan_q      <= 1'b0;
            qnan_q      <= 1'b0;
            den_q       <= 1'b0;
            fclass_q    <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sgn_q    <= s1_sgn_q;
                exp_q    <= exp_d;
                man_q    <= man_d;
                zero_q   <= zero_d;
                inf_q    <= s1_inf_q;
                snan_q   <= snan_d;
                qnan_q   <= qnan_d;
                den_q    <= s1_sub_q;
                fclass_q <= fclass_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sgn       = sgn_q;
    assign Exp       = exp_q;
    assign man       = man_q;
    assign zero      = zero_q;
    assign inf       = inf_q;
    assign sNaN      = snan_q;
    assign qNaN      = qnan_q;
    assign denormal  = den_q;
    assign fclass    = fclass_q;
endmodule

// File: tb/tb_fp_unpack.sv
// Directed-plus-random bench for fp_unpack in binary32 and binary64 shapes.
module tb_fp_unpack;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // binary32 instance
    logic        a_iv, a_rdy, a_daz, a_ov, a_ordy;
    logic [31:0] a_x;
    logic        a_sgn, a_zero, a_inf, a_snan, a_qnan, a_den;
    logic [9:0]  a_exp, a_fc;
    logic [23:0] a_man;

    // binary64 instance
    logic        b_iv, b_rdy, b_daz, b_ov, b_ordy;
    logic [63:0] b_x;
    logic        b_sgn, b_zero, b_inf, b_snan, b_qnan, b_den;
    logic [12:0] b_exp;
    logic [9:0]  b_fc;
    logic [52:0] b_man;

    fp_unpack #(.EXP_W(8), .MAN_W(23)) dut_a (
        .clk(clk), .reset(rst), .in_valid(a_iv), .in_ready(a_rdy),
        .float_in(a_x), .daz(a_daz), .out_valid(a_ov), .out_ready(a_ordy),
        .sgn(a_sgn), .Exp(a_exp), .man(a_man), .zero(a_zero), .inf(a_inf),
        .sNaN(a_snan), .qNaN(a_qnan), .denormal(a_den), .fclass(a_fc));

    fp_unpack #(.EXP_W(11), .MAN_W(52)) dut_b (
        .clk(clk), .reset(rst), .in_valid(b_iv), .in_ready(b_rdy),
        .float_in(b_x), .daz(b_daz), .out_valid(b_ov), .out_ready(b_ordy),
        .sgn(b_sgn), .Exp(b_exp), .man(b_man), .zero(b_zero), .inf(b_inf),
        .sNaN(b_snan), .qNaN(b_qnan), .denormal(b_den), .fclass(b_fc));

    // fl = {zero, inf, sNaN, qNaN, denormal}
    typedef struct packed {
        logic        sgn;
        logic [31:0] ex;
        logic [63:0] man;
        logic [4:0]  fl;
        logic [9:0]  fc;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   ntx   = 0;
    res_t sb_a[$];
    res_t sb_b[$];

    // Reference: decode the value arithmetically from the format rules.
    function automatic res_t model(input logic [63:0] x, input int ew, input int mw, input bit dz);
        res_t r;
        longint unsigned e, f, m, hid, ones;
        int s, idx;
        r    = '0;
        hid  = 64'd1 << mw;
        ones = (64'd1 << ew) - 1;
        e    = (x >> mw) & ones;
        f    = x & (hid - 1);
        r.sgn = x[ew+mw];
        if (e == 0 && f == 0) begin
            r.fl[4] = 1'b1;
            idx = r.sgn ? 3 : 4;
        end else if (e == 0) begin
            r.fl[0] = 1'b1;
            if (dz) begin
                r.fl[4] = 1'b1;
                idx = r.sgn ? 3 : 4;
            end else begin
                m = f;
                s = 0;
                while (m < hid) begin
                    m = m * 2;
                    s++;
                end
                r.man = m;
                r.ex  = 32'(1 - s);
                idx   = r.sgn ? 2 : 5;
            end
        end else if (e == ones) begin
            r.man = hid + f;
            r.ex  = 32'(e);
            if (f == 0) begin
                r.fl[3] = 1'b1;
                idx = r.sgn ? 0 : 7;
            end else if (f >= hid / 2) begin
                r.fl[1] = 1'b1;
                idx = 9;
            end else begin
                r.fl[2] = 1'b1;
                idx = 8;
            end
        end else begin
            r.man = hid + f;
            r.ex  = 32'(e);
            idx   = r.sgn ? 1 : 6;
        end
        r.fc = 10'd1 << idx;
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        if ($urandom_range(0, 2) == 0) f = f >> $urandom_range(0, 22);
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [63:0] rnd64();
        logic [10:0] e;
        logic [51:0] f;
        case ($urandom_range(0, 5))
            0:       e = 11'h000;
            1:       e = 11'h7FF;
            default: e = 11'($urandom_range(1, 2046));
        endcase
        f = ($urandom_range(0, 3) == 0) ? 52'd0 : {20'($urandom), 32'($urandom)};
        if ($urandom_range(0, 2) == 0) f = f >> $urandom_range(0, 51);
        return {1'($urandom), e, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_res(input string who, input res_t r, input logic s,
                             input logic [63:0] ex, input logic [63:0] mn,
                             input logic [4:0] fl, input logic [9:0] fc);
        ntx++;
        $display("txn %0d %s sgn=%0d exp=%0d man=%0h flags=%05b fclass=%03h",
                 ntx, who, s, $signed(ex), mn, fl, fc);
        chk({who, "_sgn"},    64'(s),  64'(r.sgn));
        chk({who, "_exp"},    ex,      64'($signed(r.ex)));
        chk({who, "_man"},    mn,      r.man);
        chk({who, "_flags"},  64'(fl), 64'(r.fl));
        chk({who, "_fclass"}, 64'(fc), 64'(r.fc));
    endtask

    // Drive at a falling edge, then let combinational ready settle.
    task automatic drive_a(input bit iv, input logic [31:0] x, input bit dz, input bit ordy);
        a_iv = iv; a_x = x; a_daz = dz; a_ordy = ordy;
        #1;
    endtask

    task automatic drive_b(input bit iv, input logic [63:0] x, input bit dz, input bit ordy);
        b_iv = iv; b_x = x; b_daz = dz; b_ordy = ordy;
        #1;
    endtask

    // Account for transfers that will happen at the coming rising edge.
    task automatic tick_a(output bit acc);
        res_t r;
        acc = a_iv && a_rdy;
        if (a_ov && a_ordy) begin
            total++;
            assert (sb_a.size() != 0) else begin
                bad++;
                $error("FAIL a_unexpected_result observed=1 expected=0");
            end
            if (sb_a.size() != 0) begin
                r = sb_a.pop_front();
                check_res("a", r, a_sgn, 64'($signed(a_exp)), 64'(a_man),
                          {a_zero, a_inf, a_snan, a_qnan, a_den}, a_fc);
            end
        end
        if (acc) sb_a.push_back(model({32'd0, a_x}, 8, 23, a_daz));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_b(output bit acc);
        res_t r;
        acc = b_iv && b_rdy;
        if (b_ov && b_ordy) begin
            total++;
            assert (sb_b.size() != 0) else begin
                bad++;
                $error("FAIL b_unexpected_result observed=1 expected=0");
            end
            if (sb_b.size() != 0) begin
                r = sb_b.pop_front();
                check_res("b", r, b_sgn, 64'($signed(b_exp)), 64'(b_man),
                          {b_zero, b_inf, b_snan, b_qnan, b_den}, b_fc);
            end
        end
        if (acc) sb_b.push_back(model(b_x, 11, 52, b_daz));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single operand through an idle pipe: latency, constants, then model.
    task automatic vec_a(input logic [31:0] x, input bit dz, input logic [9:0] fc,
                         input int exc, input logic [63:0] mnc);
        bit acc;
        drive_a(1'b1, x, dz, 1'b1);
        chk("a_vec_accept", 64'(a_rdy), 64'd1);
        tick_a(acc);
        drive_a(1'b0, 32'd0, 1'b0, 1'b1);
        chk("a_lat1_ov", 64'(a_ov), 64'd0);
        tick_a(acc);
        chk("a_lat2_ov", 64'(a_ov), 64'd1);
        chk("a_vec_fclass", 64'(a_fc), 64'(fc));
        chk("a_vec_exp", 64'($signed(a_exp)), 64'(exc));
        chk("a_vec_man", 64'(a_man), mnc);
        tick_a(acc);
    endtask

    task automatic vec_b(input logic [63:0] x, input bit dz, input logic [9:0] fc,
                         input int exc, input logic [63:0] mnc);
        bit acc;
        drive_b(1'b1, x, dz, 1'b1);
        tick_b(acc);
        drive_b(1'b0, 64'd0, 1'b0, 1'b1);
        chk("b_lat1_ov", 64'(b_ov), 64'd0);
        tick_b(acc);
        chk("b_lat2_ov", 64'(b_ov), 64'd1);
        chk("b_vec_fclass", 64'(b_fc), 64'(fc));
        chk("b_vec_exp", 64'($signed(b_exp)), 64'(exc));
        chk("b_vec_man", 64'(b_man), mnc);
        tick_b(acc);
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] ops [8];
        bit          dzs [8];
        logic [63:0] snap, cur;

        rst = 1'b1;
        a_iv = 0; a_x = '0; a_daz = 0; a_ordy = 1;
        b_iv = 0; b_x = '0; b_daz = 0; b_ordy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_outputs", {a_sgn, a_exp, a_man, a_zero, a_inf, a_snan, a_qnan, a_den, a_fc}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(a_rdy), 64'd1);
        @(negedge clk);

        // Directed classes
        vec_a(32'h3F80_0000, 1'b0, 10'h040, 127, 64'h80_0000);
        vec_a(32'h0000_0001, 1'b0, 10'h020, -22, 64'h80_0000);
        vec_a(32'h0000_0001, 1'b1, 10'h010, 0,   64'h0);
        vec_a(32'hFF80_0000, 1'b0, 10'h001, 255, 64'h80_0000);
        vec_a(32'h7FC0_0000, 1'b0, 10'h200, 255, 64'hC0_0000);
        vec_a(32'h7F80_0001, 1'b0, 10'h100, 255, 64'h80_0001);
        vec_a(32'h8000_0000, 1'b0, 10'h008, 0,   64'h0);
        vec_a(32'h8040_0000, 1'b0, 10'h004, 0,   64'h80_0000);
        vec_a(32'h807F_FFFF, 1'b1, 10'h008, 0,   64'h0);

        // Backpressure: out_ready low for cycles 3..7 of the burst
        for (int i = 0; i < 8; i++) begin
            ops[i] = rnd32();
            dzs[i] = 1'($urandom);
        end
        idx = 0;
        snap = '0;
        for (int c = 0; c < 30; c++) begin
            drive_a(idx < 8, (idx < 8) ? ops[idx] : 32'd0, (idx < 8) ? dzs[idx] : 1'b0,
                    !(c >= 3 && c < 8));
            cur = {a_ov, a_sgn, a_exp, a_man, a_zero, a_inf, a_snan, a_qnan, a_den, a_fc};
            if (c == 3) begin
                snap = cur;
                chk("bp_stall_ov", 64'(a_ov), 64'd1);
            end
            if (c > 3 && c < 8) chk("bp_hold", cur, snap);
            if (c >= 3 && c < 8) chk("bp_in_ready", 64'(a_rdy), 64'd0);
            tick_a(acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 64'(idx), 64'd8);
        chk("bp_sb_empty", 64'(sb_a.size()), 64'd0);

        // Full throughput: 100 operands, 100 results on consecutive cycles
        for (int c = 0; c < 102; c++) begin
            drive_a(c < 100, rnd32(), 1'($urandom), 1'b1);
            if (c < 100) chk("tp_in_ready", 64'(a_rdy), 64'd1);
            if (c >= 2) chk("tp_out_valid", 64'(a_ov), 64'd1);
            tick_a(acc);
        end
        drive_a(1'b0, 32'd0, 1'b0, 1'b1);
        chk("tp_drained_ov", 64'(a_ov), 64'd0);
        chk("tp_sb_empty", 64'(sb_a.size()), 64'd0);

        // Reset with both stages full
        drive_a(1'b1, rnd32(), 1'b0, 1'b0);
        tick_a(acc);
        drive_a(1'b1, rnd32(), 1'b0, 1'b0);
        tick_a(acc);
        drive_a(1'b1, rnd32(), 1'b0, 1'b0);
        chk("full_ov", 64'(a_ov), 64'd1);
        chk("full_in_ready", 64'(a_rdy), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_ov", 64'(a_ov), 64'd0);
        chk("async_rst_outputs", {a_sgn, a_exp, a_man, a_zero, a_inf, a_snan, a_qnan, a_den, a_fc}, 64'd0);
        sb_a.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_a(1'b0, 32'd0, 1'b0, 1'b1);
        chk("post_rst_in_ready", 64'(a_rdy), 64'd1);
        chk("post_rst_ov", 64'(a_ov), 64'd0);
        vec_a(32'h3F80_0000, 1'b0, 10'h040, 127, 64'h80_0000);

        // binary64 subset
        vec_b(64'h0000_0000_0000_0001, 1'b0, 10'h020, -51, 64'h10_0000_0000_0000);
        vec_b(64'h3FF0_0000_0000_0000, 1'b0, 10'h040, 1023, 64'h10_0000_0000_0000);
        vec_b(64'hFFF0_0000_0000_0000, 1'b0, 10'h001, 2047, 64'h10_0000_0000_0000);
        vec_b(64'h0008_0000_0000_0000, 1'b1, 10'h010, 0, 64'h0);
        for (int c = 0; c < 32; c++) begin
            drive_b(c < 30, rnd64(), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            tick_b(acc);
            if (c < 30 && !acc) c--;
        end
        drive_b(1'b0, 64'd0, 1'b0, 1'b1);
        repeat (3) tick_b(acc);
        chk("b_sb_empty", 64'(sb_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
